// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
//
// Time-multiplexed scan controller for a 4-digit 7-segment display. The block
// holds a 16-bit display word, four 4-bit nibbles, and drives a shared
// BCD-to-segment decoder one digit at a time. Each digit slot lasts SCAN_DIV
// clock cycles.
//
// New values are double-buffered. LOAD writes a shadow register, and the
// shadow is copied into the active word only at a frame boundary, so a new
// value never appears partway through a frame.
//
// Parameters:
//   SCAN_DIV   clock cycles per digit slot (1 .. 2**CNT_W)
//   CNT_W      prescaler width
//
// Ports:
//   CLK         in   system clock, rising edge
//   RST         in   asynchronous reset, active-high
//   DATA_IN     in   [15:0] display word; nibble i is shown on digit i
//   LOAD        in   one-cycle strobe that captures DATA_IN into the shadow
//   LZB_EN      in   leading-zero blanking enable (level)
//   BLANK_MASK  in   [3:0] bit i = 1 forces digit i dark (level)
//   PENDING     out  shadow holds data that is not yet displayed
//   BCD         out  [3:0] digit code to the decoder
//   SEL_IN      out  [1:0] digit index to the decoder select
//   BLANK       out  current digit is dark
//   FRAME_DONE  out  one-cycle pulse after the slot of digit 3 ends
// -----------------------------------------------------------------------------
module seg_scan_ctrl #(
    parameter int SCAN_DIV = 50000,
    parameter int CNT_W    = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] DATA_IN,
    input  logic        LOAD,
    input  logic        LZB_EN,
    input  logic [3:0]  BLANK_MASK,
    output logic        PENDING,
    output logic [3:0]  BCD,
    output logic [1:0]  SEL_IN,
    output logic        BLANK,
    output logic        FRAME_DONE
);

    // Last prescaler value of a slot. SCAN_DIV may equal 2**CNT_W, and
    // SCAN_DIV-1 still fits in CNT_W bits in that case.
    localparam logic [CNT_W-1:0] TICK_AT = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] count;
    logic [1:0]       idx;
    logic [15:0]      active;
    logic [15:0]      shadow;
    logic             pending_q;

    logic             tick;
    logic             boundary;
    logic [1:0]       idx_next;
    logic [15:0]      active_next;
    logic [3:0]       nibble_next;
    logic             lz_next;

    assign tick     = (count == TICK_AT);
    assign boundary = tick && (idx == 2'd3);
    assign idx_next = tick ? idx + 2'd1 : idx;

    // Active word after this edge. A LOAD on the boundary edge bypasses the
    // shadow, so the new value is visible on the very next cycle.
    always_comb begin
        active_next = active;
        if (boundary) begin
            if (LOAD) begin
                active_next = DATA_IN;
            end else if (pending_q) begin
                active_next = shadow;
            end
        end
    end

    // Decoder inputs for the post-edge digit. Leading-zero blanking darkens
    // digit idx when it and every more significant nibble are zero. Digit 0
    // is exempt, so a value of zero still shows a single "0".
    always_comb begin
        nibble_next = 4'd0;
        lz_next     = 1'b0;
        case (idx_next)
            2'd0: begin
                nibble_next = active_next[3:0];
                lz_next     = 1'b0;
            end
            2'd1: begin
                nibble_next = active_next[7:4];
                lz_next     = (active_next[15:4] == 12'd0);
            end
            2'd2: begin
                nibble_next = active_next[11:8];
                lz_next     = (active_next[15:8] == 8'd0);
            end
            default: begin
                nibble_next = active_next[15:12];
                lz_next     = (active_next[15:12] == 4'd0);
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count      <= '0;
            idx        <= 2'd0;
            active     <= 16'd0;
            shadow     <= 16'd0;
            pending_q  <= 1'b0;
            BCD        <= 4'd0;
            BLANK      <= 1'b1;
            FRAME_DONE <= 1'b0;
        end else begin
            count      <= tick ? '0 : count + CNT_W'(1);
            idx        <= idx_next;
            active     <= active_next;
            FRAME_DONE <= boundary;

            // A boundary LOAD has already gone straight to active, so nothing
            // is left pending. Otherwise a LOAD always wins over the boundary
            // drain, and the most recent write stays pending.
            if (LOAD) begin
                shadow    <= DATA_IN;
                pending_q <= !boundary;
            end else if (boundary) begin
                pending_q <= 1'b0;
            end

            // Sample the level controls only at slot changes, so a digit never
            // changes brightness partway through its slot.
            if (tick) begin
                BCD   <= nibble_next;
                BLANK <= BLANK_MASK[idx_next] | (LZB_EN & lz_next);
            end
        end
    end

    assign SEL_IN  = idx;
    assign PENDING = pending_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_ctrl
//
// Self-checking bench for seg_scan_ctrl with SCAN_DIV = 4. The prescaler is
// made as narrow as it can be (CNT_W = 2, so SCAN_DIV = 2**CNT_W).
//
// The reference model counts clock edges since reset is released. It derives
// the slot timing from that count with integer division, and derives the
// digit contents by shifting the active word.
// -----------------------------------------------------------------------------
module tb_seg_scan_ctrl;

    localparam int SCAN_DIV = 4;
    localparam int CNT_W    = 2;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] data_in = 16'd0;
    logic        load = 1'b0;
    logic        lzb_en = 1'b0;
    logic [3:0]  blank_mask = 4'd0;
    logic        pending;
    logic [3:0]  bcd;
    logic [1:0]  sel_in;
    logic        blank;
    logic        frame_done;

    always #5 clk = ~clk;

    seg_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .CNT_W(CNT_W)) dut (
        .CLK        (clk),
        .RST        (rst),
        .DATA_IN    (data_in),
        .LOAD       (load),
        .LZB_EN     (lzb_en),
        .BLANK_MASK (blank_mask),
        .PENDING    (pending),
        .BCD        (bcd),
        .SEL_IN     (sel_in),
        .BLANK      (blank),
        .FRAME_DONE (frame_done)
    );

    // ---------------- scoreboard counters ----------------
    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_cyc;      // clock edges seen since reset was released
    logic [15:0] m_active, m_shadow;
    logic        m_pending, m_blank, m_fd, m_tick;
    int          m_sel;
    logic [15:0] m_bcd;

    task automatic model_reset();
        m_cyc = 0; m_active = 0; m_shadow = 0; m_pending = 0;
        m_blank = 1; m_fd = 0; m_tick = 0; m_sel = 0; m_bcd = 0;
    endtask

    task automatic model_edge();
        logic boundary;
        int   slot_before;
        if (rst) begin
            model_reset();
            return;
        end
        m_tick      = ((m_cyc % SCAN_DIV) == SCAN_DIV - 1);
        slot_before = (m_cyc / SCAN_DIV) % 4;
        boundary    = m_tick && (slot_before == 3);
        if (load && boundary) begin
            m_active = data_in; m_shadow = data_in; m_pending = 0;
        end else if (load) begin
            m_shadow = data_in; m_pending = 1;
        end else if (boundary && m_pending) begin
            m_active = m_shadow; m_pending = 0;
        end
        m_fd = boundary;
        m_cyc++;
        if (m_tick) begin
            m_sel   = (m_cyc / SCAN_DIV) % 4;
            m_bcd   = (m_active >> (4 * m_sel)) & 16'hF;
            m_blank = blank_mask[m_sel] |
                      (lzb_en && (m_sel != 0) && ((m_active >> (4 * m_sel)) == 16'd0));
        end
    endtask

    // One clock: advance the model at the edge, then compare shortly after.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("pending",    {15'd0, pending},    {15'd0, m_pending});
        check("bcd",        {12'd0, bcd},        m_bcd);
        check("sel_in",     {14'd0, sel_in},     16'(m_sel));
        check("blank",      {15'd0, blank},      {15'd0, m_blank});
        check("frame_done", {15'd0, frame_done}, {15'd0, m_fd});
    endtask

    // Step until the model reports a slot change onto digit k (bounded).
    task automatic run_to_slot(input int k);
        for (int n = 0; n < 40; n++) begin
            step();
            if (m_tick && m_sel == k) return;
        end
        tests_run++;
        tests_failed++;
        $display("FAIL run_to_slot: digit %0d not reached within 40 cycles", k);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pending"}, {15'd0, pending},    16'd0);
        check({tag, "_bcd"},     {12'd0, bcd},        16'd0);
        check({tag, "_sel"},     {14'd0, sel_in},     16'd0);
        check({tag, "_blank"},   {15'd0, blank},      16'd1);
        check({tag, "_fd"},      {15'd0, frame_done}, 16'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int fd_count;
        model_reset();
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Idle scan after reset. The display stays dark until the first tick.
        for (int i = 0; i < 3; i++) begin
            step();
            check("pre_tick_blank", {15'd0, blank}, 16'd1);
        end
        step();
        check("first_tick_sel",   {14'd0, sel_in}, 16'd1);
        check("first_tick_blank", {15'd0, blank},  16'd0);
        run_to_slot(0);
        check("fd_pulse", {15'd0, frame_done}, 16'd1);
        fd_count = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            fd_count += int'(frame_done);
        end
        check("fd_per_frame", 16'(fd_count), 16'd1);

        // LOAD in the middle of a frame.
        step(); step();
        data_in = 16'h1234; load = 1'b1;
        step();
        load = 1'b0;
        check("mid_load_pending", {15'd0, pending}, 16'd1);
        check("mid_load_old_bcd", {12'd0, bcd}, 16'd0);
        run_to_slot(0); check("h1234_d0", {12'd0, bcd}, 16'd4);
        check("h1234_pending_clr", {15'd0, pending}, 16'd0);
        run_to_slot(1); check("h1234_d1", {12'd0, bcd}, 16'd3);
        run_to_slot(2); check("h1234_d2", {12'd0, bcd}, 16'd2);
        run_to_slot(3); check("h1234_d3", {12'd0, bcd}, 16'd1);

        // Leading-zero blanking.
        lzb_en = 1'b1; data_in = 16'h0050; load = 1'b1;
        step();
        load = 1'b0;
        run_to_slot(0); check("lz50_d0_bcd", {12'd0, bcd}, 16'd0);
        check("lz50_d0_blank", {15'd0, blank}, 16'd0);
        run_to_slot(1); check("lz50_d1_bcd", {12'd0, bcd}, 16'd5);
        check("lz50_d1_blank", {15'd0, blank}, 16'd0);
        run_to_slot(2); check("lz50_d2_blank", {15'd0, blank}, 16'd1);
        run_to_slot(3); check("lz50_d3_blank", {15'd0, blank}, 16'd1);
        data_in = 16'h0000; load = 1'b1;
        step();
        load = 1'b0;
        run_to_slot(0); check("lz0_d0_blank", {15'd0, blank}, 16'd0);
        run_to_slot(1); check("lz0_d1_blank", {15'd0, blank}, 16'd1);
        run_to_slot(2); check("lz0_d2_blank", {15'd0, blank}, 16'd1);
        run_to_slot(3); check("lz0_d3_blank", {15'd0, blank}, 16'd1);
        lzb_en = 1'b0;

        // Two loads inside one frame: the last write wins.
        run_to_slot(0);
        step();
        data_in = 16'hAAAA; load = 1'b1;
        step();
        data_in = 16'hBEEF;
        step();
        load = 1'b0;
        run_to_slot(0); check("beef_d0", {12'd0, bcd}, 16'hF);
        run_to_slot(1); check("beef_d1", {12'd0, bcd}, 16'hE);
        run_to_slot(2); check("beef_d2", {12'd0, bcd}, 16'hE);
        run_to_slot(3); check("beef_d3", {12'd0, bcd}, 16'hB);

        // LOAD on the exact boundary edge, together with a blank mask.
        step(); step(); step();
        blank_mask = 4'b0100; data_in = 16'h9876; load = 1'b1;
        step();
        load = 1'b0;
        check("bnd_d0_bcd",   {12'd0, bcd},     16'd6);
        check("bnd_pending",  {15'd0, pending}, 16'd0);
        check("bnd_sel",      {14'd0, sel_in},  16'd0);
        check("bnd_d0_blank", {15'd0, blank},   16'd0);
        run_to_slot(1); check("mask_d1_blank", {15'd0, blank}, 16'd0);
        run_to_slot(2); check("mask_d2_blank", {15'd0, blank}, 16'd1);
        check("mask_d2_bcd", {12'd0, bcd}, 16'd8);
        run_to_slot(3); check("mask_d3_blank", {15'd0, blank}, 16'd0);
        blank_mask = 4'b0000;

        // Asynchronous reset in the middle of a frame, with a load pending.
        data_in = 16'h1111; load = 1'b1;
        step();
        load = 1'b0;
        check("pre_rst_pending", {15'd0, pending}, 16'd1);
        #2 rst = 1'b1;
        #1 check_reset_outputs("async_rst");
        model_reset();
        step(); step();
        @(negedge clk);
        rst = 1'b0;
        run_to_slot(0);
        check("post_rst_bcd",     {12'd0, bcd},     16'd0);
        check("post_rst_pending", {15'd0, pending}, 16'd0);
        check("post_rst_blank",   {15'd0, blank},   16'd0);

        // Randomized traffic, checked against the model on every cycle.
        for (int i = 0; i < 800; i++) begin
            load    = ($urandom_range(0, 7) == 0);
            data_in = 16'($urandom);
            if ($urandom_range(0, 15) == 0) lzb_en = ~lzb_en;
            if ($urandom_range(0, 15) == 0) blank_mask = 4'($urandom);
            if ($urandom_range(0, 3) == 0) data_in[15:8] = 8'd0;
            step();
        end
        load = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
